// File: rtl/aes_pkg.sv
// AES-128 decipher shared package: sbox tables, GF(2^8) helpers,
// key schedule steps, InvShiftRows/InvMixColumns and FSM encoding.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE, KEXP, INIT, SUB, ADD
  } state_e;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] ISBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Table row 0 sits in the top bits, so ~x selects the byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_T[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ISBOX_T[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] mod_x_by_2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] key_fwd(
    input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    a = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    b = rk[95:64] ^ a;
    c = rk[63:32] ^ b;
    d = rk[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] key_bwd(
    input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    d = rk[31:0] ^ rk[63:32];
    c = rk[63:32] ^ rk[95:64];
    b = rk[95:64] ^ rk[127:96];
    a = rk[127:96] ^ sub_word(rot_word(d)) ^ {rc, 24'h0};
    return {a, b, c, d};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    a[0] = w[31:24]; a[1] = w[23:16];
    a[2] = w[15:8];  a[3] = w[7:0];
    for (int i = 0; i < 4; i++) begin
      x2 = mod_x_by_2(a[i]);
      x4 = mod_x_by_2(x2);
      x8 = mod_x_by_2(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // b[15] is state byte 0 (column-major order).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[15], b[2],  b[5],  b[8],
            b[11], b[14], b[1],  b[4],
            b[7],  b[10], b[13], b[0],
            b[3],  b[6],  b[9],  b[12]};
  endfunction

endpackage

// File: rtl/aes_inv_sbox_word.sv
// Combinational InvSubBytes on one 32-bit word.
// w_i: input word, w_o: inverse-sbox substituted word.
module aes_inv_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] w_i,
  input  logic        unused_i,
  output logic [31:0] w_o
);
  assign w_o = {inv_sbox(w_i[31:24]), inv_sbox(w_i[23:16]),
                inv_sbox(w_i[15:8]),  inv_sbox(w_i[7:0])};
endmodule

// File: rtl/aes_dec.sv
// AES-128 inverse cipher, iterative, one block in flight.
// Ports: clk, rst_n, s_aes_{key,block,valid,ready}, m_aes_{block,valid}.
// Optional: AES_DEC_KEY_CACHE_EN caches the last key and its rk10.
module aes_dec
  import aes_pkg::*;
#(
  parameter int FAST_MODE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] s_aes_key,
  input  logic [127:0] s_aes_block,
  input  logic         s_aes_valid,
  output logic         s_aes_ready,
  output logic [127:0] m_aes_block,
  output logic         m_aes_valid
);
  state_e       state_q, state_d;
  logic [127:0] block_q, block_d, rkey_q, rkey_d, out_q, out_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   widx_q, widx_d;
  logic         valid_q, valid_d;
  logic         hit, sub_last, kexp_last;
  logic [127:0] hit_rk, sub_blk, rk_prev, add_pre, rk_next;

  assign s_aes_ready = (state_q == IDLE);
  assign m_aes_block = out_q;
  assign m_aes_valid = valid_q;
  assign kexp_last   = (state_q == KEXP) && (round_q == 4'd9);
  assign rk_next     = key_fwd(rkey_q, rcon_q);
  assign rk_prev     = key_bwd(rkey_q, rcon_q);
  assign add_pre     = inv_shift_rows(block_q) ^ rk_prev;

  if (FAST_MODE != 0) begin : g_fast
    for (genvar i = 0; i < 4; i++) begin : g_w
      aes_inv_sbox_word u_sb (
        .w_i      (block_q[32*i +: 32]),
        .unused_i (1'b0),
        .w_o      (sub_blk[32*i +: 32])
      );
    end
    assign sub_last = 1'b1;
  end else begin : g_slow
    logic [31:0] w_in, w_out;
    always_comb begin
      w_in = block_q[127:96];
      unique case (widx_q)
        2'd0: w_in = block_q[127:96];
        2'd1: w_in = block_q[95:64];
        2'd2: w_in = block_q[63:32];
        2'd3: w_in = block_q[31:0];
      endcase
    end
    aes_inv_sbox_word u_sb (
      .w_i      (w_in),
      .unused_i (1'b0),
      .w_o      (w_out)
    );
    always_comb begin
      sub_blk = block_q;
      unique case (widx_q)
        2'd0: sub_blk[127:96] = w_out;
        2'd1: sub_blk[95:64]  = w_out;
        2'd2: sub_blk[63:32]  = w_out;
        2'd3: sub_blk[31:0]   = w_out;
      endcase
    end
    assign sub_last = (widx_q == 2'd3);
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ckey_q, crk_q;
  logic         cvld_q;
  assign hit    = cvld_q && (s_aes_key == ckey_q);
  assign hit_rk = crk_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckey_q <= '0;
      crk_q  <= '0;
      cvld_q <= 1'b0;
    end else if (kexp_last) begin
      crk_q  <= rk_next;
      cvld_q <= 1'b1;
    end else if (s_aes_valid && s_aes_ready && !hit) begin
      // rk10 is stale until this expansion finishes
      ckey_q <= s_aes_key;
      cvld_q <= 1'b0;
    end
  end
`else
  assign hit    = 1'b0;
  assign hit_rk = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (s_aes_valid) state_d = hit ? INIT : KEXP;
      KEXP: if (round_q == 4'd9) state_d = INIT;
      INIT: state_d = SUB;
      SUB:  if (sub_last) state_d = ADD;
      ADD:  state_d = (round_q == 4'd0) ? IDLE : SUB;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    block_d = block_q;
    rkey_d  = rkey_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    widx_d  = widx_q;
    out_d   = out_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (s_aes_valid) begin
        block_d = s_aes_block;
        round_d = 4'd0;
        rkey_d  = hit ? hit_rk : s_aes_key;
        rcon_d  = hit ? RCON_LAST : RCON_FIRST;
      end
      KEXP: begin
        rkey_d = rk_next;
        // rcon stays at rcon_10 for the backward walk
        if (round_q != 4'd9) begin
          rcon_d  = mod_x_by_2(rcon_q);
          round_d = round_q + 4'd1;
        end
      end
      INIT: begin
        block_d = block_q ^ rkey_q;
        round_d = 4'd9;
        widx_d  = 2'd0;
      end
      SUB: begin
        block_d = sub_blk;
        widx_d  = widx_q + 2'd1;
      end
      ADD: begin
        rkey_d = rk_prev;
        rcon_d = inv_xtime(rcon_q);
        if (round_q != 4'd0) begin
          block_d = {inv_mix_col(add_pre[127:96]),
                     inv_mix_col(add_pre[95:64]),
                     inv_mix_col(add_pre[63:32]),
                     inv_mix_col(add_pre[31:0])};
          round_d = round_q - 4'd1;
        end else begin
          out_d   = add_pre;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      rkey_q  <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      widx_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      block_q <= block_d;
      rkey_q  <= rkey_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      widx_q  <= widx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_aes_dec.sv
// Scoreboard bench for aes_dec: fast and slow instances,
// FIPS-197 vectors, back-to-back, busy, reset, key cache.
module tb_aes_dec;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key, blk;
  logic         vf, vs, rf, rs, mvf, mvs;
  logic [127:0] mbf, mbs;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           t0;
  } exp_t;
  exp_t qf[$], qs[$];
  exp_t ef, es;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int LHIT = 22;
`else
  localparam int LHIT = 32;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec #(.FAST_MODE(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .s_aes_key(key), .s_aes_block(blk),
    .s_aes_valid(vf), .s_aes_ready(rf),
    .m_aes_block(mbf), .m_aes_valid(mvf)
  );

  aes_dec #(.FAST_MODE(0)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .s_aes_key(key), .s_aes_block(blk),
    .s_aes_valid(vs), .s_aes_ready(rs),
    .m_aes_block(mbs), .m_aes_valid(mvs)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (mvf) begin
      if (qf.size() == 0) chk("fast_spurious_valid", 1, 0);
      else begin
        ef = qf.pop_front();
        chk("fast_plaintext", mbf, ef.pt);
        chk("fast_latency", 128'(cyc - ef.t0), 128'(ef.lat));
      end
    end
    if (mvs) begin
      if (qs.size() == 0) chk("slow_spurious_valid", 1, 0);
      else begin
        es = qs.pop_front();
        chk("slow_plaintext", mbs, es.pt);
        chk("slow_latency", 128'(cyc - es.t0), 128'(es.lat));
      end
    end
  end

  task automatic issue(input bit slow, input logic [127:0] k,
                       input logic [127:0] c, input logic [127:0] p,
                       input int lat, output int t0);
    exp_t e;
    int n;
    n = 0;
    while (!(slow ? rs : rf) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", 0, 1);
    key = k;
    blk = c;
    e.pt = p;
    e.lat = lat;
    e.t0 = cyc;
    t0 = cyc;
    if (slow) begin vs = 1'b1; qs.push_back(e); end
    else begin vf = 1'b1; qf.push_back(e); end
    @(negedge clk);
    vf = 1'b0;
    vs = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qf.size() != 0 || qs.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", qf.size() + qs.size(), 0);
  endtask

  initial begin
    int t1, t2, n;
    key = '0; blk = '0; vf = 1'b0; vs = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", mvf, 0);
    chk("reset_block", mbf, 0);
    chk("reset_ready", rf, 1);

    issue(0, K1, C1, P1, 32, t1);
    drain();

    issue(1, K2, C2, P2, 62, t1);
    repeat (10) @(negedge clk);
    chk("slow_rk10", u_slow.rkey_q, RK10B);
    drain();

    issue(0, K1, C1, P1, LHIT, t1);
    issue(0, K2, C2, P2, 32, t2);
    chk("b2b_no_bubble", 128'(t2), 128'(t1 + LHIT));
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if (rf) n++;
      @(negedge clk);
    end
    chk("b2b_ready_low", n, 0);
    drain();

    issue(0, K1, C1, P1, 32, t1);
    repeat (5) @(negedge clk);
    key = {$urandom, $urandom, $urandom, $urandom};
    blk = {$urandom, $urandom, $urandom, $urandom};
    vf = 1'b1;
    @(negedge clk);
    vf = 1'b0;
    drain();

    issue(0, K1, C1, P1, LHIT, t1);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", mvf, 0);
    chk("abort_block", mbf, 0);
    qf.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", rf, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (mvf) n++;
      @(negedge clk);
    end
    chk("abort_no_pulse", n, 0);

    issue(0, K1, C1, P1, 32, t1);
    drain();
    issue(0, K1, C1, P1, LHIT, t1);
    drain();
    issue(0, K2, C2, P2, 32, t1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
